// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: a single full-subtractor cell walks the operands
// LSB first, one bit per clock, and publishes diff/bout when the last bit is done.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       cell_s;

    // Returns {borrow_out, difference_bit} of one full-subtractor cell.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        full_sub = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    assign cell_s = full_sub(a_r[0], b_r[0], br_r);

    // Control FSM, serial datapath and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= {WIDTH{1'b0}};
            bout    <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    // start is deliberately not looked at here
                    res_r <= {cell_s[0], res_r[WIDTH-1:1]};
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    br_r  <= cell_s[1];
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= {cell_s[0], res_r[WIDTH-1:1]};
                        bout    <= cell_s[1];
                    end else begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        a_r     <= a;
                        b_r     <= b;
                        br_r    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand and result width in bits (legal range 2 to 32).
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled on the rising edge.
REQ-005 SHALL have port: a  input  WIDTH  minuend, unsigned; sampled only on the edge where start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, unsigned; sampled only on the edge where start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a subtraction is in progress (RUN state).
REQ-008 SHALL have port: done  output  1  single-cycle pulse marking a completed result.
REQ-009 SHALL have port: diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 SHALL have port: bout  output  1  borrow out; 1 when a < b (unsigned).

Function
REQ-011 SHALL implement a bit-serial subtractor: one full-subtractor bit cell, LSB first, one bit per clock.
REQ-012 SHALL use an FSM with three states: IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE.
REQ-014 SHALL, on accepting start: latch a and b into shift registers, clear the internal borrow flop, load the bit counter with 0, and enter RUN.
REQ-015 SHALL, on each RUN edge: compute d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br); shift d into the MSB of the working result; shift both operand registers right by one; increment the counter.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, i.e. after exactly WIDTH RUN edges.
REQ-017 SHALL, on the RUN-to-DONE edge, load diff with the full working result and bout with the final borrow.
REQ-018 SHALL give a latency of WIDTH+1 cycles: start accepted at edge k gives done high in the cycle after edge k+WIDTH.
REQ-019 SHALL hold done high for exactly one cycle (DONE state).
REQ-020 SHALL move DONE to RUN if start is high in DONE (back-to-back operation), otherwise DONE to IDLE.
REQ-021 SHALL drive busy = 1 exactly when the state is RUN.
REQ-022 SHALL ignore start while in RUN; operand registers are not reloaded and the operation continues unchanged.
REQ-023 SHALL keep diff and bout stable from the completion edge until the next completion edge, including throughout a following RUN.
REQ-024 SHALL treat a and b as don't-care except on the edge where start is accepted.
REQ-025 SHALL produce no combinational path from any input to any output.

Reset
REQ-026 SHALL, with rst_n low at a rising edge, enter IDLE and clear: operand registers, working result, borrow flop, counter, busy, done, diff and bout.
REQ-027 SHALL, when reset occurs mid-RUN, abort the operation: no done pulse, and diff/bout read 0.
REQ-028 SHALL ignore start on any edge where rst_n is low.
REQ-029 SHALL accept start on the first edge with rst_n high.

Verification
REQ-030 SHALL cover: WIDTH=8, a=5, b=3, start pulse at edge 0 -> busy high for 8 cycles; done in the cycle after edge 8; diff=0x02, bout=0.
REQ-031 SHALL cover: a=3, b=5 -> diff=0xFE, bout=1; a=0x00, b=0xFF -> diff=0x01, bout=1; a=b=0xA5 -> diff=0x00, bout=0.
REQ-032 SHALL cover: start re-pulsed mid-RUN with new operands 0xFF/0x01 -> ignored; original result delivered at the original completion time.
REQ-033 SHALL cover: start held high through DONE with a=0x10, b=0x01 -> next RUN begins immediately; first diff stays stable during that RUN; second done gives diff=0x0F.
REQ-034 SHALL cover: rst_n low at edge 4 of a RUN -> IDLE; no done pulse; diff=0, bout=0, busy=0; a new start on the following edge completes normally.
REQ-035 SHALL cover: randomized a and b at WIDTH=8 and WIDTH=16 -> every result matches the reference model {bout, diff} = {1'b0, a} - {1'b0, b} (borrow taken as the sign bit), with latency WIDTH+1.
